pipeline_ctrl: RTL and testbench

Central hazard/exception controller for the 5-stage MIPS core: it produces the per-stage `stall` and global `flush` controls consumed by every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC redirect target on exceptions and `eret`. It arbitrates stall requests from IF, ID, EX and MEM. It sequences exception flushes so that a redirect never fires while an instruction fetch is in flight. It also keeps a saturating stall-cycle counter for profiling.

---
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/exception controller for the 5-stage core: per-stage stall bits, global flush,
// PC redirect target on exceptions/eret, and a saturating stall-cycle profiling counter.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_req_if,
    input  logic                 stall_req_id,
    input  logic                 stall_req_ex,
    input  logic                 stall_req_mem,
    input  logic                 exc_valid,
    input  logic                 exc_is_eret,
    input  logic [31:0]          cp0_epc,
    output logic [5:0]           stall,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 busy_flush,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] STALL_HOLD = 6'b011111;

    state_t               state_q, state_d;
    logic [31:0]          cap_q, cap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [5:0]           req_stall;
    logic [31:0]          exc_target;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Highest-indexed requester wins; each pattern freezes its stage and all upstream ones.
    always_comb begin
        if (stall_req_mem)
            req_stall = 6'b001111;
        else if (stall_req_ex)
            req_stall = 6'b000111;
        else if (stall_req_id)
            req_stall = 6'b000011;
        else if (stall_req_if)
            req_stall = 6'b000001;
        else
            req_stall = 6'b000000;
    end

    assign exc_target = exc_is_eret ? cp0_epc : EXC_ENTRY;

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        stall    = req_stall;
        flush    = 1'b0;
        flush_pc = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    if (stall_req_if) begin
                        // Fetch still in flight: hold the excepting instruction until it returns.
                        stall   = STALL_HOLD;
                        cap_d   = exc_target;
                        state_d = S_WAIT;
                    end else begin
                        stall    = 6'b000000;
                        flush    = 1'b1;
                        flush_pc = exc_target;
                    end
                end
            end
            S_WAIT: begin
                if (stall_req_if) begin
                    stall = STALL_HOLD;
                end else begin
                    stall    = 6'b000000;
                    flush    = 1'b1;
                    flush_pc = cap_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Controls stay quiet while reset is asserted, whatever the requesters do.
        if (!rst) begin
            stall    = 6'b000000;
            flush    = 1'b0;
            flush_pc = 32'h0;
        end

        cnt_d = (stall[0] && !flush) ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cap_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_flush   = (state_q == S_WAIT);
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by random traffic, all checked
// against an event-level reference model of the stall/flush rules.
module tb_pipeline_ctrl;

    localparam int          CW    = 6;
    localparam logic [31:0] ENTRY = 32'hBFC00380;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall_req_if = 1'b0, stall_req_id = 1'b0;
    logic          stall_req_ex = 1'b0, stall_req_mem = 1'b0;
    logic          exc_valid = 1'b0, exc_is_eret = 1'b0;
    logic [31:0]   cp0_epc = 32'h0;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          busy_flush;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_ctrl #(.EXC_ENTRY(ENTRY), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req_if (stall_req_if),
        .stall_req_id (stall_req_id),
        .stall_req_ex (stall_req_ex),
        .stall_req_mem(stall_req_mem),
        .exc_valid    (exc_valid),
        .exc_is_eret  (exc_is_eret),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .busy_flush   (busy_flush),
        .stall_cycles (stall_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: is a redirect pending, where to, and how many stalled cycles so far.
    bit          m_wait = 1'b0;
    logic [31:0] m_held = 32'h0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ri, input bit rd, input bit re, input bit rm,
                        input bit ev, input bit er, input logic [31:0] epc);
        logic [5:0]  e_stall;
        bit          e_flush;
        logic [31:0] e_pc;
        logic [31:0] tgt;
        int          n;
        @(negedge clk);
        rst           = r;
        stall_req_if  = ri;
        stall_req_id  = rd;
        stall_req_ex  = re;
        stall_req_mem = rm;
        exc_valid     = ev;
        exc_is_eret   = er;
        cp0_epc       = epc;
        #1;
        if (!r) begin
            m_wait = 1'b0;
            m_held = 32'h0;
            m_cnt  = 0;
        end
        tgt     = er ? epc : ENTRY;
        e_stall = 6'b0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        if (r) begin
            if (m_wait) begin
                if (ri) e_stall = 6'b011111;
                else begin e_flush = 1'b1; e_pc = m_held; end
            end else if (ev) begin
                if (ri) e_stall = 6'b011111;
                else begin e_flush = 1'b1; e_pc = tgt; end
            end else begin
                n = rm ? 4 : re ? 3 : rd ? 2 : ri ? 1 : 0;
                e_stall = 6'((1 << n) - 1);
            end
        end
        chk("stall",        {58'b0, stall},        {58'b0, e_stall});
        chk("flush",        {63'b0, flush},        {63'b0, e_flush});
        chk("flush_pc",     {32'b0, flush_pc},     {32'b0, e_pc});
        chk("busy_flush",   {63'b0, busy_flush},   {63'b0, m_wait});
        chk("stall_cycles", {{(64-CW){1'b0}}, stall_cycles}, 64'(m_cnt));
        if (r) begin
            if (e_stall[0] && !e_flush && m_cnt < (1 << CW) - 1)
                m_cnt++;
            if (m_wait && !ri)
                m_wait = 1'b0;
            else if (!m_wait && ev && ri) begin
                m_wait = 1'b1;
                m_held = tgt;
            end
        end
    endtask

    initial begin
        // Reset held with every requester active, then released
        repeat (3) step(0, 1, 1, 1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 1, 1, 0, 0, 32'h0);
        // Priority between ID and EX, then EX dropped
        step(1, 0, 1, 1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Immediate exception, alone and together with a MEM stall request
        step(1, 0, 0, 0, 0, 1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 1, 1, 32'h12345678);
        // Deferred eret: EPC changes and a second exception arrive during the wait
        step(1, 1, 0, 0, 0, 1, 1, 32'h80001234);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 1, 1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Reset in the middle of a wait discards the pending redirect
        step(1, 1, 0, 0, 0, 1, 0, 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Counter: five MEM stalls, then long enough to saturate
        repeat (5) step(1, 0, 0, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        repeat (70) step(1, 0, 0, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 1) == 1),
                 $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
